// File: rtl/wb_pkg.sv
// Shared types and helpers for the stream-to-Wishbone writer.
// State encoding and address alignment helper.
package wb_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      WAIT_DATA = 3'd2,
      WB_WRITE  = 3'd3,
      DONE      = 3'd4
   } state_t;

   function automatic int adr_lsb(input int sel_w);
      return (sel_w <= 1) ? 0 : $clog2(sel_w);
   endfunction

endpackage

// File: rtl/wb_stream_to_mem.sv
// Wishbone master draining a valid/ready stream into consecutive
// memory words; single classic writes, one word in flight.
module wb_stream_to_mem
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 16,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8,
   parameter int LEN_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ADDR_WIDTH-1:0]   cfg_base_adr,
   input  logic [LEN_WIDTH-1:0]    cfg_len,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [LEN_WIDTH-1:0]    words_written,
   input  logic [DATA_WIDTH-1:0]   s_tdata,
   input  logic                    s_tvalid,
   output logic                    s_tready,
   input  logic                    s_tlast,
   output logic [ADDR_WIDTH-1:0]   m_adr_o,
   output logic [DATA_WIDTH-1:0]   m_dat_o,
   output logic                    m_we_o,
   output logic [SELECT_WIDTH-1:0] m_sel_o,
   output logic                    m_stb_o,
   output logic                    m_cyc_o,
   input  logic                    m_ack_i,
   input  logic                    m_err_i
);

   localparam int LSB = adr_lsb(SELECT_WIDTH);
   localparam logic [SELECT_WIDTH-1:0] SEL_ALL = '1;
   localparam logic [ADDR_WIDTH-1:0] ADR_STEP = ADDR_WIDTH'(SELECT_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ADR_MASK = ~(ADDR_WIDTH'((1 << LSB) - 1));

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
   logic [DATA_WIDTH-1:0]   dat_q, dat_d;
   logic [LEN_WIDTH-1:0]    rem_q, rem_d;
   logic [LEN_WIDTH-1:0]    ww_q, ww_d;
   logic [SELECT_WIDTH-1:0] sel_q, sel_d;
   logic                    cyc_q, cyc_d;
   logic                    we_q, we_d;
   logic                    last_q, last_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic                    rdy_q, rdy_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         adr_q   <= '0;
         dat_q   <= '0;
         rem_q   <= '0;
         ww_q    <= '0;
         sel_q   <= '0;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         rem_q   <= rem_d;
         ww_q    <= ww_d;
         sel_q   <= sel_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdy_q   <= rdy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      rem_d   = rem_q;
      ww_d    = ww_q;
      sel_d   = sel_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      rdy_d   = rdy_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               adr_d   = cfg_base_adr & ADR_MASK;
               rem_d   = cfg_len;
               ww_d    = '0;
               err_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (rem_q == '0) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               rdy_d   = 1'b1;
               state_d = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            if (s_tvalid && rdy_q) begin
               dat_d   = s_tdata;
               last_d  = s_tlast;
               cyc_d   = 1'b1;
               we_d    = 1'b1;
               sel_d   = SEL_ALL;
               rdy_d   = 1'b0;
               state_d = WB_WRITE;
            end
         end
         WB_WRITE: begin
            // err wins over a simultaneous ack; the word is not counted
            if (m_err_i) begin
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               sel_d   = '0;
               err_d   = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end else if (m_ack_i) begin
               cyc_d = 1'b0;
               we_d  = 1'b0;
               sel_d = '0;
               ww_d  = ww_q + 1'b1;
               adr_d = adr_q + ADR_STEP;
               rem_d = rem_q - 1'b1;
               if (rem_q == LEN_WIDTH'(1) || last_q) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  rdy_d   = 1'b1;
                  state_d = WAIT_DATA;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign words_written = ww_q;
   assign s_tready      = rdy_q;
   assign m_adr_o       = adr_q;
   assign m_dat_o       = dat_q;
   assign m_we_o        = we_q;
   assign m_sel_o       = sel_q;
   assign m_stb_o       = cyc_q;
   assign m_cyc_o       = cyc_q;

endmodule

// File: tb/tb_wb_stream_to_mem.sv
// Bench for wb_stream_to_mem: registered-ack memory slave with
// error injection and an address/data scoreboard on each ack.
module tb_wb_stream_to_mem;

   logic        clk;
   logic        rst_n;
   logic [15:0] cfg_base_adr;
   logic [15:0] cfg_len;
   logic        start;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] words_written;
   logic [31:0] s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic        s_tlast;
   logic [15:0] m_adr_o;
   logic [31:0] m_dat_o;
   logic        m_we_o;
   logic [3:0]  m_sel_o;
   logic        m_stb_o;
   logic        m_cyc_o;
   logic        s_ack;
   logic        s_err;

   wb_stream_to_mem dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_base_adr  (cfg_base_adr),
      .cfg_len       (cfg_len),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .words_written (words_written),
      .s_tdata       (s_tdata),
      .s_tvalid      (s_tvalid),
      .s_tready      (s_tready),
      .s_tlast       (s_tlast),
      .m_adr_o       (m_adr_o),
      .m_dat_o       (m_dat_o),
      .m_we_o        (m_we_o),
      .m_sel_o       (m_sel_o),
      .m_stb_o       (m_stb_o),
      .m_cyc_o       (m_cyc_o),
      .m_ack_i       (s_ack),
      .m_err_i       (s_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [0:16383];
   logic [47:0] exp_q[$];
   int wr_idx  = 0;
   int err_at  = -1;
   int ack_cnt = 0;
   int mon_chk = 0;
   int mon_err = 0;
   int checks  = 0;
   int errors  = 0;

   // slave: ack/err one cycle after stb, never back-to-back
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ack <= 1'b0;
         s_err <= 1'b0;
      end else begin
         s_ack <= 1'b0;
         s_err <= 1'b0;
         if (m_cyc_o && m_stb_o && !s_ack && !s_err) begin
            if (wr_idx == err_at) begin
               s_err <= 1'b1;
            end else begin
               s_ack <= 1'b1;
               mem[m_adr_o[15:2]] = m_dat_o;
               ack_cnt++;
               mon_chk++;
               if (exp_q.size() == 0) begin
                  mon_err++;
                  $display("FAIL sb_unexpected_write got=%h_%h want=none",
                           m_adr_o, m_dat_o);
               end else begin
                  logic [47:0] e;
                  e = exp_q.pop_front();
                  if ({m_adr_o, m_dat_o} !== e || m_sel_o !== 4'hF || !m_we_o) begin
                     mon_err++;
                     $display("FAIL sb_write got=%h_%h sel=%h we=%b want=%h sel=f we=1",
                              m_adr_o, m_dat_o, m_sel_o, m_we_o, e);
                  end
               end
            end
            wr_idx++;
         end
      end
   end

   int done_cnt  = 0;
   int cyc_cnt   = 0;
   int rdy_cnt   = 0;
   int overlap   = 0;
   always @(posedge clk) begin
      if (rst_n) begin
         done_cnt += int'(done);
         cyc_cnt  += int'(m_cyc_o);
         rdy_cnt  += int'(s_tready);
         overlap  += int'(done & busy);
      end
   end

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic do_start(input logic [15:0] base, input logic [15:0] len);
      @(negedge clk);
      cfg_base_adr = base;
      cfg_len      = len;
      start        = 1'b1;
      @(negedge clk);
      start        = 1'b0;
   endtask

   task automatic send_word(input string name, input logic [31:0] data,
                            input bit last, input bit push,
                            input logic [15:0] adr);
      bit ok;
      ok       = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = data;
      s_tlast  = last;
      for (int i = 0; i < 50; i++) begin
         if (s_tready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) begin
         if (push) exp_q.push_back({adr, data});
         @(posedge clk);
         @(negedge clk);
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      if (!ok) chk({name, "_handshake_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic wait_done(input string name, input int d0);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk({name, "_done_seen"}, 64'(seen), 64'd1);
      repeat (3) @(negedge clk);
      chk({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
      chk({name, "_busy_after"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int d0, a0, c0, r0;
      rst_n        = 1'b0;
      cfg_base_adr = '0;
      cfg_len      = '0;
      start        = 1'b0;
      s_tdata      = '0;
      s_tvalid     = 1'b0;
      s_tlast      = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cyc", 64'(m_cyc_o), 64'd0);
      chk("rst_stb", 64'(m_stb_o), 64'd0);
      chk("rst_we", 64'(m_we_o), 64'd0);
      chk("rst_sel", 64'(m_sel_o), 64'd0);
      chk("rst_flags", 64'({busy, done, err, s_tready}), 64'd0);
      chk("rst_adr", 64'(m_adr_o), 64'd0);
      chk("rst_dat", 64'(m_dat_o), 64'd0);
      chk("rst_ww", 64'(words_written), 64'd0);
      rst_n = 1'b1;

      // plain 4-word transfer
      d0 = done_cnt; a0 = ack_cnt;
      do_start(16'h0100, 16'd4);
      chk("t1_busy", 64'(busy), 64'd1);
      send_word("t1w0", 32'h11, 1'b0, 1'b1, 16'h0100);
      send_word("t1w1", 32'h22, 1'b0, 1'b1, 16'h0104);
      send_word("t1w2", 32'h33, 1'b0, 1'b1, 16'h0108);
      send_word("t1w3", 32'h44, 1'b0, 1'b1, 16'h010C);
      wait_done("t1", d0);
      chk("t1_ww", 64'(words_written), 64'd4);
      chk("t1_err", 64'(err), 64'd0);
      chk("t1_acks", 64'(ack_cnt - a0), 64'd4);
      chk("t1_mem40", 64'(mem[14'h40]), 64'h11);
      chk("t1_mem41", 64'(mem[14'h41]), 64'h22);
      chk("t1_mem42", 64'(mem[14'h42]), 64'h33);
      chk("t1_mem43", 64'(mem[14'h43]), 64'h44);

      // tlast on the third of eight words ends early
      d0 = done_cnt; a0 = ack_cnt;
      do_start(16'h0200, 16'd8);
      send_word("t2w0", 32'hA1, 1'b0, 1'b1, 16'h0200);
      send_word("t2w1", 32'hA2, 1'b0, 1'b1, 16'h0204);
      send_word("t2w2", 32'hA3, 1'b1, 1'b1, 16'h0208);
      wait_done("t2", d0);
      chk("t2_ww", 64'(words_written), 64'd3);
      chk("t2_acks", 64'(ack_cnt - a0), 64'd3);
      r0 = rdy_cnt;
      s_tvalid = 1'b1;
      s_tdata  = 32'hBAD;
      repeat (10) @(negedge clk);
      s_tvalid = 1'b0;
      chk("t2_rdy_after", 64'(rdy_cnt - r0), 64'd0);

      // zero length: done two cycles after start, no bus or stream activity
      d0 = done_cnt; c0 = cyc_cnt; r0 = rdy_cnt;
      s_tvalid = 1'b1;
      do_start(16'h0300, 16'd0);
      chk("t3_done_early", 64'(done), 64'd0);
      @(negedge clk);
      chk("t3_done_at2", 64'(done), 64'd1);
      chk("t3_busy_at2", 64'(busy), 64'd0);
      repeat (4) @(negedge clk);
      s_tvalid = 1'b0;
      chk("t3_pulses", 64'(done_cnt - d0), 64'd1);
      chk("t3_cyc", 64'(cyc_cnt - c0), 64'd0);
      chk("t3_rdy", 64'(rdy_cnt - r0), 64'd0);
      chk("t3_ww", 64'(words_written), 64'd0);

      // address wrap at top of the byte space
      d0 = done_cnt;
      do_start(16'hFFF8, 16'd4);
      send_word("t4w0", 32'hC0, 1'b0, 1'b1, 16'hFFF8);
      send_word("t4w1", 32'hC1, 1'b0, 1'b1, 16'hFFFC);
      send_word("t4w2", 32'hC2, 1'b0, 1'b1, 16'h0000);
      send_word("t4w3", 32'hC3, 1'b0, 1'b1, 16'h0004);
      wait_done("t4", d0);
      chk("t4_mem3fff", 64'(mem[14'h3FFF]), 64'hC1);
      chk("t4_mem0", 64'(mem[14'h0]), 64'hC2);
      chk("t4_mem1", 64'(mem[14'h1]), 64'hC3);

      // bus error on the second write, then a clean restart clears err
      d0 = done_cnt;
      err_at = wr_idx + 1;
      do_start(16'h0400, 16'd4);
      send_word("t5w0", 32'hD0, 1'b0, 1'b1, 16'h0400);
      send_word("t5w1", 32'hD1, 1'b0, 1'b0, 16'h0404);
      wait_done("t5", d0);
      chk("t5_err", 64'(err), 64'd1);
      chk("t5_ww", 64'(words_written), 64'd1);
      err_at = -1;
      d0 = done_cnt;
      do_start(16'h0500, 16'd1);
      chk("t5_err_cleared", 64'(err), 64'd0);
      send_word("t5w2", 32'hD2, 1'b0, 1'b1, 16'h0500);
      wait_done("t5b", d0);
      chk("t5b_err", 64'(err), 64'd0);
      chk("t5b_ww", 64'(words_written), 64'd1);

      // reset while a write is on the bus
      do_start(16'h0600, 16'd2);
      send_word("t6w0", 32'hE0, 1'b0, 1'b0, 16'h0600);
      chk("t6_cyc_before", 64'(m_cyc_o), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_cyc_rst", 64'(m_cyc_o), 64'd0);
      chk("t6_stb_rst", 64'(m_stb_o), 64'd0);
      chk("t6_busy_rst", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      d0 = done_cnt;
      do_start(16'h0700, 16'd2);
      send_word("t6w1", 32'hF0, 1'b0, 1'b1, 16'h0700);
      send_word("t6w2", 32'hF1, 1'b0, 1'b1, 16'h0704);
      wait_done("t6", d0);
      chk("t6_ww", 64'(words_written), 64'd2);
      chk("t6_mem1c0", 64'(mem[14'h1C0]), 64'hF0);
      chk("t6_mem1c1", 64'(mem[14'h1C1]), 64'hF1);

      chk("busy_done_overlap", 64'(overlap), 64'd0);
      chk("sb_left", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks",
               errors + mon_err, checks + mon_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
